// File: rtl/ram_march_bist.sv
// March C- built-in self-test engine driving a synchronous single-port RAM.
module ram_march_bist #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [7:0]            err_count
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ONES      = {DATA_WIDTH{1'b1}};

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_CHK, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    wr_phase_q, wr_phase_d;   // 0 = RD sub-phase, 1 = WR sub-phase
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic                    we_d, busy_d, done_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic                    clear_c;
    logic                    rd_c;
    logic [DATA_WIDTH-1:0]   exp_c;

    logic                    cmp_pending;
    logic [DATA_WIDTH-1:0]   cmp_exp;
    logic [ADDR_WIDTH-1:0]   cmp_addr;
    logic                    miscompare;

    // State, address and RAM-side output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_phase_q <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_phase_q <= wr_phase_d;
            mem_addr   <= addr_d;
            mem_we     <= we_d;
            mem_wdata  <= wdata_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // March sequencing: next state, sub-phase, address and the registered output values.
    always_comb begin
        state_d    = state_q;
        wr_phase_d = 1'b0;
        addr_d     = mem_addr;
        clear_c    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                addr_d = '0;
                if (start) begin
                    state_d = S_M0;
                    clear_c = 1'b1;
                end
            end
            S_M0: begin
                if (mem_addr == ADDR_LAST) begin
                    state_d = S_M1;
                    addr_d  = '0;
                end else begin
                    addr_d = mem_addr + ADDR_WIDTH'(1);
                end
            end
            S_M1, S_M2: begin
                if (!wr_phase_q) begin
                    wr_phase_d = 1'b1;
                end else if (mem_addr == ADDR_LAST) begin
                    state_d = (state_q == S_M1) ? S_M2 : S_M3;
                    addr_d  = (state_q == S_M1) ? '0 : ADDR_LAST;
                end else begin
                    addr_d = mem_addr + ADDR_WIDTH'(1);
                end
            end
            S_M3, S_M4: begin
                if (!wr_phase_q) begin
                    wr_phase_d = 1'b1;
                end else if (mem_addr == '0) begin
                    state_d = (state_q == S_M3) ? S_M4 : S_M5;
                    addr_d  = ADDR_LAST;
                end else begin
                    addr_d = mem_addr - ADDR_WIDTH'(1);
                end
            end
            S_M5: begin
                if (mem_addr == '0) begin
                    state_d = S_CHK;
                    addr_d  = '0;
                end else begin
                    addr_d = mem_addr - ADDR_WIDTH'(1);
                end
            end
            S_CHK: begin
                state_d = S_DONE;
                addr_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase

        we_d    = (state_d == S_M0) ||
                  (((state_d == S_M1) || (state_d == S_M2) ||
                    (state_d == S_M3) || (state_d == S_M4)) && wr_phase_d);
        wdata_d = ((state_d == S_M1) || (state_d == S_M3)) ? ONES : '0;
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
    end

    // Current cycle is a RAM read; expected background for that read.
    always_comb begin
        rd_c  = (state_q == S_M5) ||
                (((state_q == S_M1) || (state_q == S_M2) ||
                  (state_q == S_M3) || (state_q == S_M4)) && !wr_phase_q);
        exp_c = ((state_q == S_M2) || (state_q == S_M4)) ? ONES : '0;
        miscompare = cmp_pending && (mem_rdata != cmp_exp);
    end

    // Compare pipeline and sticky result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_pending <= 1'b0;
            cmp_exp     <= '0;
            cmp_addr    <= '0;
            fail        <= 1'b0;
            fail_addr   <= '0;
            fail_data   <= '0;
            err_count   <= 8'd0;
        end else if (clear_c) begin
            cmp_pending <= 1'b0;
            cmp_exp     <= '0;
            cmp_addr    <= '0;
            fail        <= 1'b0;
            fail_addr   <= '0;
            fail_data   <= '0;
            err_count   <= 8'd0;
        end else begin
            cmp_pending <= rd_c;
            cmp_exp     <= exp_c;
            cmp_addr    <= mem_addr;
            if (miscompare) begin
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
                if (!fail) begin
                    fail      <= 1'b1;
                    fail_addr <= cmp_addr;
                    fail_data <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_march_bist.sv
// Self-checking bench for ram_march_bist with behavioural RAMs and a March C- reference model.
module tb_ram_march_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy, done, fail;
    logic [3:0] fail_addr;
    logic [7:0] fail_data;
    logic [7:0] err_count;

    // Second instance with a larger array so the error counter can saturate.
    logic       start_s;
    logic       mem_we_s;
    logic [5:0] mem_addr_s;
    logic [7:0] mem_wdata_s;
    logic [7:0] mem_rdata_s;
    logic       busy_s, done_s, fail_s;
    logic [5:0] fail_addr_s;
    logic [7:0] fail_data_s;
    logic [7:0] err_count_s;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram   [16];
    logic [7:0] or_mask [16];
    logic [7:0] ram_s [64];

    logic [18:0] exp_q[$];
    int          m_err;
    bit          m_fail;
    int          m_faddr;
    logic [7:0]  m_fdata;

    always #5 clk = ~clk;

    ram_march_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
        .fail_data(fail_data), .err_count(err_count)
    );

    ram_march_bist #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s),
        .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s), .mem_rdata(mem_rdata_s),
        .busy(busy_s), .done(done_s), .fail(fail_s), .fail_addr(fail_addr_s),
        .fail_data(fail_data_s), .err_count(err_count_s)
    );

    // RAM with registered read; stuck-at-1 faults applied on the read path.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        else        mem_rdata <= ram[mem_addr] | or_mask[mem_addr];
    end

    // RAM whose every read returns the inverted word.
    always @(posedge clk) begin
        if (mem_we_s) ram_s[mem_addr_s] <= mem_wdata_s;
        else          mem_rdata_s <= ~ram_s[mem_addr_s];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // March C- over an abstract 16-word memory: per-cycle pin expectations and final results.
    task automatic build_model();
        logic [7:0] m [16];
        logic [7:0] wd, rv, obs;
        int a;
        exp_q.delete();
        m_err = 0; m_fail = 0; m_faddr = 0; m_fdata = 8'h00;
        for (int i = 0; i < 16; i++) m[i] = 8'h00;
        for (int e = 0; e < 6; e++) begin
            wd = (e == 1 || e == 3) ? 8'hFF : 8'h00;
            for (int i = 0; i < 16; i++) begin
                a = (e < 3) ? i : 15 - i;
                if (e >= 1) begin
                    rv  = (e == 2 || e == 4) ? 8'hFF : 8'h00;
                    exp_q.push_back({1'b1, 1'b0, 1'b0, 8'(a), wd});
                    obs = m[a] | or_mask[a];
                    if (obs != rv) begin
                        if (m_err < 255) m_err++;
                        if (!m_fail) begin
                            m_fail = 1; m_faddr = a; m_fdata = obs;
                        end
                    end
                end
                if (e <= 4) begin
                    exp_q.push_back({1'b1, 1'b0, 1'b1, 8'(a), wd});
                    m[a] = wd;
                end
            end
        end
        exp_q.push_back({1'b1, 1'b0, 1'b0, 8'd0, 8'h00});
    endtask

    // One full run from IDLE/DONE; optional ignored start pulse at cycle 'glitch'.
    task automatic run_test(input string name, input int glitch);
        build_model();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= exp_q.size(); c++) begin
            start = (c == glitch);
            check({name, "_cyc"}, {busy, done, mem_we, 8'(mem_addr), mem_wdata}, 32'(exp_q[c-1]));
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({name, "_busy_end"}, 32'(busy), 32'd0);
        check({name, "_done"},     32'(done), 32'd1);
        check({name, "_fail"},     32'(fail), 32'(m_fail));
        check({name, "_faddr"},    32'(fail_addr), 32'(m_faddr));
        check({name, "_fdata"},    32'(fail_data), 32'(m_fdata));
        check({name, "_errcnt"},   32'(err_count), 32'(m_err));
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 16; i++) or_mask[i] = 8'h00;
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_we"},     32'(mem_we), 32'd0);
        check({name, "_addr"},   32'(mem_addr), 32'd0);
        check({name, "_wdata"},  32'(mem_wdata), 32'd0);
        check({name, "_busy"},   32'(busy), 32'd0);
        check({name, "_done"},   32'(done), 32'd0);
        check({name, "_fail"},   32'(fail), 32'd0);
        check({name, "_faddr"},  32'(fail_addr), 32'd0);
        check({name, "_fdata"},  32'(fail_data), 32'd0);
        check({name, "_errcnt"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        int g, nf, cyc;
        rst_n = 1'b0;
        start = 1'b0;
        start_s = 1'b0;
        clear_faults();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean RAM
        run_test("clean", 0);

        // Stuck-at-1 on bit 3 of word 5
        or_mask[5] = 8'h08;
        run_test("stuck", 0);
        check("stuck_err_direct",   32'(err_count), 32'd3);
        check("stuck_faddr_direct", 32'(fail_addr), 32'd5);
        check("stuck_fdata_direct", 32'(fail_data), 32'h08);

        // Fault removed, start from DONE
        clear_faults();
        run_test("b2b_clean", 0);

        // Start while busy is ignored
        run_test("glitch40", 40);

        // Reset mid-run with a fault already recorded
        or_mask[5] = 8'h08;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #3;
        check("pre_rst_fail", 32'(fail), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_faults();
        @(posedge clk); #1;
        run_test("after_rst", 0);

        // Randomized fault patterns and stray start pulses
        for (int r = 0; r < 5; r++) begin
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int k = 0; k < nf; k++)
                or_mask[$urandom_range(0, 15)] = 8'($urandom_range(1, 255));
            g = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 160) : 0;
            run_test("rand", g);
        end
        clear_faults();
        run_test("final_clean", 0);

        // Saturation: every read of a 64-word RAM miscompares (320 reads)
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        cyc = 1;
        while (!done_s && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("sat_len",    32'(cyc), 32'd642);
        check("sat_done",   32'(done_s), 32'd1);
        check("sat_errcnt", 32'(err_count_s), 32'd255);
        check("sat_fail",   32'(fail_s), 32'd1);
        check("sat_faddr",  32'(fail_addr_s), 32'd0);
        check("sat_fdata",  32'(fail_data_s), 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
